// File: rtl/rf_write_arbiter_if.sv
// Requester-side bundle for rf_write_arbiter: per-requester valid/lock/payload and one-hot ready.
// Requester k owns bit k of valid/lock/ready and slice k of each payload vector.
interface rf_write_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_lock;
    logic [4*NREQ-1:0]    req_regsel;
    logic [4*NREQ-1:0]    req_scrsel;
    logic [3*NREQ-1:0]    req_funsel;
    logic [32*NREQ-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;

    modport master (
        output req_valid, req_lock, req_regsel, req_scrsel, req_funsel, req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_lock, req_regsel, req_scrsel, req_funsel, req_data,
        output req_ready
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter with multi-beat lock for the RegisterFile write port (I/RegSel/ScrSel/FunSel).
// Optional lock-timeout breaker enabled by defining RF_ARB_TIMEOUT_EN.
module rf_write_arbiter #(
    parameter int NREQ         = 2,
    parameter int LOCK_TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              rst,
    rf_write_arbiter_if.slave req,
    output logic [3:0]        RegSel,
    output logic [3:0]        ScrSel,
    output logic [2:0]        FunSel,
    output logic [31:0]       I,
    output logic [1:0]        grant_id,
    output logic              locked,
    output logic              lock_broken
);
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  grant_id_q, grant_id_d;
    logic [3:0]  regsel_q, regsel_d;
    logic [3:0]  scrsel_q, scrsel_d;
    logic [2:0]  funsel_q, funsel_d;
    logic [31:0] data_q, data_d;
    logic        lock_broken_q, lock_broken_d;
    logic        fire_s;
    logic        lock_s;
    logic [1:0]  gidx_s;
    logic [NREQ-1:0] ready_s;
`ifdef RF_ARB_TIMEOUT_EN
    logic [3:0]  idle_cnt_q, idle_cnt_d;
`endif

    function automatic logic [1:0] wrap_add(input logic [1:0] base, input int offs);
        return 2'((int'(base) + offs) % NREQ);
    endfunction

    function automatic logic valid_at(input logic [NREQ-1:0] vec, input logic [1:0] idx);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            hit = hit | (vec[k] & (idx == 2'(k)));
        end
        return hit;
    endfunction

    // Grant selection: owner only while locked, else first valid scanning upward from ptr.
    always_comb begin
        fire_s = 1'b0;
        gidx_s = 2'd0;
        if (rst) begin
            if (state_q == LOCKED) begin
                fire_s = valid_at(req.req_valid, owner_q);
                gidx_s = owner_q;
            end else begin
                // Scan farthest-first so the requester nearest to ptr overwrites last and wins.
                for (int i = NREQ - 1; i >= 0; i--) begin
                    fire_s = fire_s | valid_at(req.req_valid, wrap_add(ptr_q, i));
                    gidx_s = valid_at(req.req_valid, wrap_add(ptr_q, i)) ? wrap_add(ptr_q, i) : gidx_s;
                end
            end
        end else begin
            fire_s = 1'b0;
        end
        ready_s = fire_s ? ({{(NREQ-1){1'b0}}, 1'b1} << gidx_s) : '0;
    end

    assign req.req_ready = ready_s;

    // Next state, pointer/owner update and staging of the accepted beat.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        grant_id_d    = grant_id_q;
        lock_broken_d = lock_broken_q;
        regsel_d      = 4'd0;
        scrsel_d      = 4'd0;
        funsel_d      = 3'd0;
        data_d        = 32'd0;
        lock_s        = 1'b0;
`ifdef RF_ARB_TIMEOUT_EN
        idle_cnt_d    = 4'd0;
`endif
        for (int k = 0; k < NREQ; k++) begin
            regsel_d = (fire_s && gidx_s == 2'(k)) ? req.req_regsel[4*k +: 4]  : regsel_d;
            scrsel_d = (fire_s && gidx_s == 2'(k)) ? req.req_scrsel[4*k +: 4]  : scrsel_d;
            funsel_d = (fire_s && gidx_s == 2'(k)) ? req.req_funsel[3*k +: 3]  : funsel_d;
            data_d   = (fire_s && gidx_s == 2'(k)) ? req.req_data[32*k +: 32]  : data_d;
            lock_s   = (fire_s && gidx_s == 2'(k)) ? req.req_lock[k]           : lock_s;
        end
        if (fire_s) begin
            grant_id_d = gidx_s;
            ptr_d      = wrap_add(gidx_s, 1);
            if (lock_s) begin
                state_d = LOCKED;
                owner_d = gidx_s;
            end else begin
                state_d = IDLE;
            end
        end else begin
`ifdef RF_ARB_TIMEOUT_EN
            // Owner idle in LOCKED: the break takes effect next cycle, this cycle stays locked.
            if (state_q == LOCKED) begin
                if (5'(idle_cnt_q) + 5'd1 == 5'(LOCK_TIMEOUT)) begin
                    state_d       = IDLE;
                    ptr_d         = wrap_add(owner_q, 1);
                    lock_broken_d = 1'b1;
                    idle_cnt_d    = 4'd0;
                end else begin
                    idle_cnt_d    = idle_cnt_q + 4'd1;
                end
            end else begin
                idle_cnt_d = 4'd0;
            end
`else
            lock_broken_d = 1'b0;
`endif
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!rst) begin
            state_q       <= IDLE;
            ptr_q         <= 2'd0;
            owner_q       <= 2'd0;
            grant_id_q    <= 2'd0;
            regsel_q      <= 4'd0;
            scrsel_q      <= 4'd0;
            funsel_q      <= 3'd0;
            data_q        <= 32'd0;
            lock_broken_q <= 1'b0;
`ifdef RF_ARB_TIMEOUT_EN
            idle_cnt_q    <= 4'd0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            grant_id_q    <= grant_id_d;
            regsel_q      <= regsel_d;
            scrsel_q      <= scrsel_d;
            funsel_q      <= funsel_d;
            data_q        <= data_d;
            lock_broken_q <= lock_broken_d;
`ifdef RF_ARB_TIMEOUT_EN
            idle_cnt_q    <= idle_cnt_d;
`endif
        end
    end

    assign RegSel      = regsel_q;
    assign ScrSel      = scrsel_q;
    assign FunSel      = funsel_q;
    assign I           = data_q;
    assign grant_id    = grant_id_q;
    assign locked      = (state_q == LOCKED);
    assign lock_broken = lock_broken_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus randomized traffic against a
// behavioural model of the grant rules and the one-cycle registered write port.
module tb_rf_write_arbiter;
    localparam int NREQ         = 2;
    localparam int LOCK_TIMEOUT = 15;

    logic        clk;
    logic        rst;
    logic [3:0]  RegSel;
    logic [3:0]  ScrSel;
    logic [2:0]  FunSel;
    logic [31:0] I;
    logic [1:0]  grant_id;
    logic        locked;
    logic        lock_broken;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_ptr, m_locked, m_owner, m_gid, m_broken, m_idle;
    int last_g;

    rf_write_arbiter_if #(.NREQ(NREQ)) rif ();

    rf_write_arbiter #(.NREQ(NREQ), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
        .Clock(clk), .rst(rst), .req(rif),
        .RegSel(RegSel), .ScrSel(ScrSel), .FunSel(FunSel), .I(I),
        .grant_id(grant_id), .locked(locked), .lock_broken(lock_broken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic v, input logic lk, input logic [3:0] rs,
                           input logic [3:0] ss, input logic [2:0] fs, input logic [31:0] d);
        rif.req_valid[k]          = v;
        rif.req_lock[k]           = lk;
        rif.req_regsel[4*k +: 4]  = rs;
        rif.req_scrsel[4*k +: 4]  = ss;
        rif.req_funsel[3*k +: 3]  = fs;
        rif.req_data[32*k +: 32]  = d;
    endtask

    task automatic clear_all();
        for (int k = 0; k < NREQ; k++) set_req(k, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0, 32'd0);
    endtask

    // One clock cycle: check ready against the model, clock, check the registered port.
    task automatic step(input string tag);
        int g;
        logic [NREQ-1:0] e_ready;
        logic [3:0]  e_rs, e_ss;
        logic [2:0]  e_fs;
        logic [31:0] e_d;
        #1;
        g = -1;
        if (rst) begin
            if (m_locked != 0) begin
                if (rif.req_valid[m_owner]) g = m_owner;
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    if (g < 0 && rif.req_valid[(m_ptr + i) % NREQ]) g = (m_ptr + i) % NREQ;
                end
            end
        end
        e_ready = '0;
        if (g >= 0) e_ready[g] = 1'b1;
        check({tag, ".ready"}, 32'(rif.req_ready), 32'(e_ready));
        e_rs = 4'd0; e_ss = 4'd0; e_fs = 3'd0; e_d = 32'd0;
        if (!rst) begin
            m_ptr = 0; m_locked = 0; m_owner = 0; m_gid = 0; m_broken = 0; m_idle = 0;
        end else if (g >= 0) begin
            e_rs = rif.req_regsel[4*g +: 4];
            e_ss = rif.req_scrsel[4*g +: 4];
            e_fs = rif.req_funsel[3*g +: 3];
            e_d  = rif.req_data[32*g +: 32];
            m_gid = g;
            m_ptr = (g + 1) % NREQ;
            m_idle = 0;
            if (rif.req_lock[g]) begin
                m_locked = 1; m_owner = g;
            end else begin
                m_locked = 0;
            end
        end else if (m_locked != 0) begin
`ifdef RF_ARB_TIMEOUT_EN
            m_idle++;
            if (m_idle == LOCK_TIMEOUT) begin
                m_locked = 0; m_ptr = (m_owner + 1) % NREQ; m_broken = 1; m_idle = 0;
            end
`endif
        end
        last_g = g;
        @(posedge clk);
        #1;
        check({tag, ".RegSel"},      32'(RegSel),      32'(e_rs));
        check({tag, ".ScrSel"},      32'(ScrSel),      32'(e_ss));
        check({tag, ".FunSel"},      32'(FunSel),      32'(e_fs));
        check({tag, ".I"},           I,                e_d);
        check({tag, ".grant_id"},    32'(grant_id),    32'(m_gid));
        check({tag, ".locked"},      32'(locked),      32'(m_locked));
        check({tag, ".lock_broken"}, 32'(lock_broken), 32'(m_broken));
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        step(tag);
        step(tag);
        rst = 1'b1;
    endtask

    task automatic new_beat(input int k, input logic v);
        set_req(k, v, 1'($urandom_range(0, 2) == 0), 4'($urandom), 4'($urandom),
                3'($urandom), 32'($urandom));
    endtask

    initial begin
        rst = 1'b0;
        last_g = -1;
        clear_all();

        // T1: single beat, visible for exactly one cycle
        do_reset("t1_rst");
        set_req(0, 1'b1, 1'b0, 4'b1000, 4'b0000, 3'b010, 32'hDEAD_BEEF);
        step("t1_beat");
        check("t1_regsel_seen", 32'(RegSel), 32'h8);
        clear_all();
        step("t1_idle");
        check("t1_regsel_zero", 32'(RegSel), 32'h0);

        // T2: two continuous requesters alternate
        do_reset("t2_rst");
        set_req(0, 1'b1, 1'b0, 4'h1, 4'h0, 3'd1, 32'h1000_0001);
        set_req(1, 1'b1, 1'b0, 4'h2, 4'h0, 3'd2, 32'h2000_0002);
        for (int b = 0; b < 4; b++) begin
            step("t2_beat");
            check("t2_gid_order", 32'(grant_id), 32'(b % 2));
            set_req(last_g, 1'b1, 1'b0, 4'($urandom_range(1, 15)), 4'($urandom), 3'($urandom),
                    32'($urandom));
        end
        clear_all();
        step("t2_idle");

        // T3: req1 lock holds off req0 until the unlocking beat
        do_reset("t3_rst");
        set_req(1, 1'b1, 1'b1, 4'h4, 4'h0, 3'd3, 32'h0000_0031);
        step("t3_lock");
        set_req(0, 1'b1, 1'b0, 4'h5, 4'h0, 3'd4, 32'h0000_0005);
        set_req(1, 1'b1, 1'b1, 4'h6, 4'h0, 3'd5, 32'h0000_0032);
        step("t3_hold1");
        set_req(1, 1'b1, 1'b1, 4'h7, 4'h0, 3'd6, 32'h0000_0033);
        step("t3_hold2");
        set_req(1, 1'b1, 1'b0, 4'h9, 4'h0, 3'd7, 32'h0000_0034);
        step("t3_release");
        set_req(1, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0, 32'h0);
        step("t3_req0");
        check("t3_req0_gid", 32'(grant_id), 32'd0);
        clear_all();
        step("t3_idle");

        // T4: reset right after a handshake
        set_req(1, 1'b1, 1'b1, 4'hA, 4'h3, 3'd1, 32'hCAFE_0004);
        step("t4_beat");
        rst = 1'b0;
        step("t4_rst");
        check("t4_locked_cleared", 32'(locked), 32'd0);
        rst = 1'b1;
        set_req(0, 1'b1, 1'b0, 4'h3, 4'h0, 3'd0, 32'h0000_0044);
        step("t4_ptr0");
        clear_all();
        step("t4_idle");

        // T5: owner goes idle while holding the lock
        do_reset("t5_rst");
        set_req(0, 1'b1, 1'b1, 4'h2, 4'h0, 3'd0, 32'h0000_0050);
        step("t5_lock");
        set_req(0, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0, 32'h0);
        set_req(1, 1'b1, 1'b0, 4'hB, 4'h0, 3'd2, 32'h0000_0051);
        for (int c = 0; c < LOCK_TIMEOUT + 4; c++) step("t5_wait");
`ifdef RF_ARB_TIMEOUT_EN
        check("t5_broken_sticky", 32'(lock_broken), 32'd1);
`else
        check("t5_still_locked", 32'(locked), 32'd1);
`endif
        clear_all();
        do_reset("t5_clear");

        // T6: null beat from req1 still consumes a slot
        set_req(0, 1'b1, 1'b0, 4'h1, 4'h0, 3'd0, 32'h0000_0060);
        step("t6_req0");
        clear_all();
        set_req(1, 1'b1, 1'b0, 4'h0, 4'h0, 3'd5, 32'h0000_0061);
        step("t6_null");
        set_req(0, 1'b1, 1'b0, 4'h2, 4'h0, 3'd0, 32'h0000_0062);
        set_req(1, 1'b1, 1'b0, 4'h3, 4'h0, 3'd0, 32'h0000_0063);
        step("t6_after");
        check("t6_ptr_wrapped", 32'(grant_id), 32'd0);
        clear_all();
        step("t6_idle");

        // Randomized traffic with protocol-respecting requesters
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 63) != 0);
            step("rnd");
            for (int k = 0; k < NREQ; k++) begin
                if (k == last_g) new_beat(k, 1'($urandom_range(0, 1)));
                else if (!rif.req_valid[k] && $urandom_range(0, 1) == 1) new_beat(k, 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
